// File: rtl/prescaled_counter_pkg.sv
// prescaled_counter_pkg
//   Shared encodings for the prescaled LED counter.
//   - mode_t : counter stepping mode as presented on the 2-bit mode port
//   - dir_t  : bounce direction (only stored when PRESCALED_COUNTER_BOUNCE_EN
//              is defined)
package prescaled_counter_pkg;

    typedef enum logic [1:0] {
        MODE_UP     = 2'b00,
        MODE_DOWN   = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

endpackage

// File: rtl/tick_gen.sv
// tick_gen
//   Prescaler producing a registered one-cycle enable pulse every DIV
//   enabled clock cycles. With DIV==1 the pulse stays high while en=1.
//   Ports:
//     clk     in  oscillator clock, all logic on posedge
//     rst_btn in  synchronous active-low reset
//     en      in  run enable; low freezes the prescaler (value held)
//     clear   in  synchronous clear of prescaler and tick
//     tick    out registered one-cycle pulse
module tick_gen #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic rst_btn,
    input  logic en,
    input  logic clear,
    output logic tick
);

    localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] presc;

    always_ff @(posedge clk) begin
        if (!rst_btn) begin
            presc <= '0;
            tick  <= 1'b0;
        end else if (clear) begin
            presc <= '0;
            tick  <= 1'b0;
        end else if (en) begin
            if (presc == LAST) begin
                presc <= '0;
                tick  <= 1'b1;
            end else begin
                presc <= presc + PW'(1);
                tick  <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/prescaled_counter.sv
// prescaled_counter
//   Divides the oscillator into a one-cycle tick (DIV = CLK_HZ/TICK_HZ) and
//   steps a WIDTH-bit count on each tick in up, down, bounce or hold mode.
//   Optional feature macro: PRESCALED_COUNTER_BOUNCE_EN
//     defined     : bounce mode and the direction register are present
//     not defined : mode 2'b10 behaves exactly like hold
//   Ports:
//     clk     in  oscillator clock
//     rst_btn in  synchronous active-low reset
//     en      in  run enable for the prescaler
//     clear   in  synchronous clear of count, prescaler and direction
//     mode    in  00 up, 01 down, 10 bounce, 11 hold
//     led     out current count (always <= MAX_COUNT)
//     tick    out one-cycle prescaler pulse
//     wrap    out one-cycle pulse on an up/down wrap step
module prescaled_counter
    import prescaled_counter_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 12000000,
    parameter int unsigned TICK_HZ   = 1,
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MAX_COUNT = 2**WIDTH - 1
) (
    input  logic             clk,
    input  logic             rst_btn,
    input  logic             en,
    input  logic             clear,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] led,
    output logic             tick,
    output logic             wrap
);

    localparam int unsigned DIV = CLK_HZ / TICK_HZ;
    localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] led_nxt;
    logic             wrap_nxt;

    tick_gen #(
        .DIV(DIV)
    ) u_tick_gen (
        .clk    (clk),
        .rst_btn(rst_btn),
        .en     (en),
        .clear  (clear),
        .tick   (tick)
    );

`ifdef PRESCALED_COUNTER_BOUNCE_EN
    dir_t dir;
    dir_t dir_nxt;
    logic going_up;
`endif

    always_comb begin
        led_nxt  = led;
        wrap_nxt = 1'b0;
`ifdef PRESCALED_COUNTER_BOUNCE_EN
        dir_nxt  = dir;
        going_up = 1'b0;
`endif
        case (mode_t'(mode))
            MODE_UP: begin
                if (led == MAX) begin
                    led_nxt  = '0;
                    wrap_nxt = 1'b1;
                end else begin
                    led_nxt = led + ONE;
                end
            end
            MODE_DOWN: begin
                if (led == '0) begin
                    led_nxt  = MAX;
                    wrap_nxt = 1'b1;
                end else begin
                    led_nxt = led - ONE;
                end
            end
`ifdef PRESCALED_COUNTER_BOUNCE_EN
            MODE_BOUNCE: begin
                // A stored direction can point past an endpoint if up/down
                // mode moved the count there; turn around instead of
                // leaving the 0..MAX range.
                going_up = ((dir == DIR_UP) && (led != MAX)) ||
                           ((dir == DIR_DOWN) && (led == '0));
                if (going_up) begin
                    led_nxt = led + ONE;
                    dir_nxt = (led_nxt == MAX) ? DIR_DOWN : DIR_UP;
                end else begin
                    led_nxt = led - ONE;
                    dir_nxt = (led_nxt == '0) ? DIR_UP : DIR_DOWN;
                end
            end
`endif
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_btn) begin
            led  <= '0;
            wrap <= 1'b0;
        end else if (clear) begin
            led  <= '0;
            wrap <= 1'b0;
        end else if (tick) begin
            led  <= led_nxt;
            wrap <= wrap_nxt;
        end else begin
            wrap <= 1'b0;
        end
    end

`ifdef PRESCALED_COUNTER_BOUNCE_EN
    always_ff @(posedge clk) begin
        if (!rst_btn || clear) begin
            dir <= DIR_UP;
        end else if (tick) begin
            dir <= dir_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_prescaled_counter.sv
// tb_prescaled_counter
//   Directed bench for prescaled_counter with DIV=4, WIDTH=3, MAX_COUNT=5.
//   A cycle-level integer model is compared against led/tick/wrap every
//   cycle; directed literal expectations pin the model.
module tb_prescaled_counter;

    localparam int DIV = 4;
    localparam int MAXC = 5;

    logic       clk;
    logic       rst_btn;
    logic       en;
    logic       clear;
    logic [1:0] mode;
    logic [2:0] led;
    logic       tick;
    logic       wrap;

    int tests = 0;
    int fails = 0;
    bit checking = 0;

    prescaled_counter #(
        .CLK_HZ   (8),
        .TICK_HZ  (2),
        .WIDTH    (3),
        .MAX_COUNT(5)
    ) dut (
        .clk    (clk),
        .rst_btn(rst_btn),
        .en     (en),
        .clear  (clear),
        .mode   (mode),
        .led    (led),
        .tick   (tick),
        .wrap   (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_presc = 0;
    int m_led   = 0;
    bit m_tick  = 0;
    bit m_wrap  = 0;
    bit m_down  = 0;

    always @(posedge clk) begin
        bit step;
        if (!rst_btn || clear) begin
            m_presc = 0; m_led = 0; m_tick = 0; m_wrap = 0; m_down = 0;
        end else begin
            step = m_tick;
            if (en) begin
                m_presc = (m_presc + 1) % DIV;
                m_tick  = (m_presc == 0);
            end else begin
                m_tick = 0;
            end
            m_wrap = 0;
            if (step) begin
                case (mode)
                    2'd0: begin
                        m_led = (m_led + 1) % (MAXC + 1);
                        m_wrap = (m_led == 0);
                    end
                    2'd1: begin
                        m_wrap = (m_led == 0);
                        m_led = (m_led + MAXC) % (MAXC + 1);
                    end
`ifdef PRESCALED_COUNTER_BOUNCE_EN
                    2'd2: begin
                        if (!m_down) begin
                            m_led = m_led + 1;
                            if (m_led == MAXC) m_down = 1;
                        end else begin
                            m_led = m_led - 1;
                            if (m_led == 0) m_down = 0;
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            chk("model_led", led, m_led);
            chk("model_tick", tick, m_tick);
            chk("model_wrap", wrap, m_wrap);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step_cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        do begin
            step_cyc();
            n++;
        end while (tick !== 1'b1 && n < 40);
        if (tick !== 1'b1) chk("tick_timeout", tick, 1);
    endtask

    task automatic do_step(output int n, output logic [2:0] l, output logic w);
        wait_tick(n);
        step_cyc();
        l = led;
        w = wrap;
    endtask

    int         n;
    logic [2:0] l;
    logic       w;
    int         up_exp[6]  = '{1, 2, 3, 4, 5, 0};
`ifdef PRESCALED_COUNTER_BOUNCE_EN
    int         bn_exp[12] = '{1, 2, 3, 4, 5, 4, 3, 2, 1, 0, 1, 2};
    localparam int PEND_EXP = 3;
`else
    int         bn_exp[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    localparam int PEND_EXP = 1;
`endif

    initial begin
        rst_btn = 1'b0; en = 1'b0; clear = 1'b0; mode = 2'b00;
        step_cyc();
        step_cyc();
        checking = 1;
        chk("reset_led", led, 0);
        chk("reset_tick", tick, 0);
        chk("reset_wrap", wrap, 0);

        // Up mode: first tick after DIV edges, then one period per step
        rst_btn = 1'b1; en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            do_step(n, l, w);
            chk("up_period", n, (k == 0) ? 4 : 3);
            chk("up_led", l, up_exp[k]);
            chk("up_wrap", w, (k == 5) ? 1 : 0);
        end

        // Down mode from 0
        mode = 2'b01;
        do_step(n, l, w);
        chk("down_led0", l, 5);
        chk("down_wrap0", w, 1);
        do_step(n, l, w);
        chk("down_led1", l, 4);
        chk("down_wrap1", w, 0);

        // Clear, then bounce
        clear = 1'b1;
        step_cyc();
        chk("clear_led", led, 0);
        clear = 1'b0;
        mode = 2'b10;
        for (int k = 0; k < 12; k++) begin
            do_step(n, l, w);
            chk("bounce_period", n, (k == 0) ? 4 : 3);
            chk("bounce_led", l, bn_exp[k]);
            chk("bounce_wrap", w, 0);
        end

        // en low for 10 cycles mid-period delays the tick by 10
        mode = 2'b00;
        step_cyc();
        en = 1'b0;
        repeat (10) step_cyc();
        en = 1'b1;
        wait_tick(n);
        chk("en_gap_edges", 1 + 10 + n, 13);

        // en drops while tick is high: pending step still happens
        en = 1'b0;
        step_cyc();
        chk("pending_step_led", led, PEND_EXP);
        en = 1'b1;

        // Clear on the tick cycle discards the step
        wait_tick(n);
        chk("held_presc_period", n, 4);
        clear = 1'b1;
        step_cyc();
        chk("clear_tick_led", led, 0);
        chk("clear_tick_tick", tick, 0);
        clear = 1'b0;
        wait_tick(n);
        chk("after_clear_period", n, 4);
        step_cyc();
        chk("after_clear_led", led, 1);

        do_step(n, l, w);
        chk("up2_led", l, 2);
        do_step(n, l, w);
        chk("up3_led", l, 3);

        // Hold mode keeps the count
        mode = 2'b11;
        do_step(n, l, w);
        chk("hold_period", n, 3);
        chk("hold_led", l, 3);
        chk("hold_wrap", w, 0);

        // Synchronous reset mid-count while a step is pending
        mode = 2'b00;
        wait_tick(n);
        rst_btn = 1'b0;
        #1;
        chk("pre_reset_led", led, 3);
        chk("pre_reset_tick", tick, 1);
        step_cyc();
        chk("reset_mid_led", led, 0);
        chk("reset_mid_tick", tick, 0);
        chk("reset_mid_wrap", wrap, 0);
        step_cyc();
        rst_btn = 1'b1;
        wait_tick(n);
        chk("post_reset_period", n, 4);
        step_cyc();
        chk("post_reset_led", led, 1);

        repeat (3) step_cyc();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL global_timeout: got %0d expected %0d", 1, 0);
        $fatal(1, "timeout");
    end

endmodule
